regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/wn/d) among NREQ write-back requesters, e.g. ALU, load unit and mul/div unit.
- Uses round-robin arbitration with a valid/ready handshake and registers the winning write one cycle before it reaches the register file.
- Holds a pending-write scoreboard, set by issue and cleared at commit, so decode can detect RAW hazards on rs/rt.
- Sits between the execute/memory stages and the register file write-back inputs.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_wn  in  NREQ*ADDR_W  destination index; requester i at bits [i*ADDR_W +: ADDR_W].
- req_d  in  NREQ*DATA_W  write data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant; the transfer occurs when req_valid[i] and req_ready[i] are both high.
- we  out  1  register-file write enable (registered).
- wn  out  ADDR_W  register-file write index (registered).
- d  out  DATA_W  register-file write data (registered).
- set_en  in  1  issue stage marks set_wn as pending.
- set_wn  in  ADDR_W  index to mark pending.
- rs  in  ADDR_W  decode source A index.
- rt  in  ADDR_W  decode source B index.
- busy_rs  out  1  rs has an uncommitted write (combinational).
- busy_rt  out  1  rt has an uncommitted write (combinational).

Behaviour:
- Reset (rst=1 at posedge):
  - we=0, wn=0, d=0.
  - Round-robin pointer = 0.
  - All scoreboard bits = 0.
  - req_ready is forced to 0 while rst=1.
  - A write already in the output register when rst is asserted is discarded (we=0 next cycle).
- Arbitration (combinational):
  - Search req_valid starting at the pointer and wrapping modulo NREQ; the first valid index wins.
  - req_ready is one-hot on the winner, or all-zero if no requester is valid.
  - req_ready never depends on anything except req_valid, the pointer and rst, so there is no backpressure path.
- Pointer update: after a grant to index g, the pointer becomes (g+1) mod NREQ. With no grant, the pointer holds.
- Output register:
  - On the cycle after a grant: we=1, wn=granted req_wn, d=granted req_d.
  - With no grant, we=0 and wn/d hold their previous values.
  - Latency is exactly 1 cycle from handshake to we; throughput is 1 write per cycle.
- Writes to $zero: a granted request with wn=0 is still handshaken, but produces we=0.
- Scoreboard (bits 1..31; bit 0 is permanently 0):
  - Set: on set_en, bit[set_wn] goes to 1.
  - Clear: when the output register commits (we=1), bit[wn] goes to 0 in that same posedge.
  - Same index set and cleared in one cycle: set wins, because a newer issue is outstanding.
  - set_en with set_wn=0 is ignored.
  - Setting an already-set bit is legal (no count); the scoreboard tracks at most one outstanding write per register, which the issue stage guarantees.
- busy_rs = bit[rs]; busy_rt = bit[rt]. The reads are combinational and reflect state before the current edge.
- Requesters may change or drop req_valid without a handshake; no stability rule is required.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, four outputs are added:
  - fwd_a_hit = we && (wn==rs) && (rs!=0); fwd_a_data = d.
  - fwd_b_hit and fwd_b_data are the same for rt.
  - busy_rs/busy_rt are masked to 0 when the matching fwd hit is 1, because the committing value is forwarded.
- When not defined, these ports are absent and busy_* are unmasked.

Decomposition:
- Shared package regfile_pkg:
  - Constants REG_ZERO=0, NUM_REGS=32, ADDR_W=5, DATA_W=32.
  - Named register indices ($sp=29, $ra=31) for benches.
- Sub-module rr_arbiter: a generic NREQ round-robin grant generator with a pointer, taking req in and giving a one-hot grant out. The data mux, output register and scoreboard stay in the top module.

Test Plan:
- Single write: req_valid=001, wn=8, d=0xDEADBEEF -> req_ready=001 in the same cycle; next cycle we=1, wn=8, d=0xDEADBEEF; following cycle we=0.
- Contention: req_valid=111 held for 6 cycles, pointer=0 after reset -> grant sequence 001, 010, 100, 001, 010, 100; we=1 every cycle after the first.
- $zero write: req_valid=010, wn=0, d=0x1234 -> req_ready=010, next cycle we=0; a subsequent read shows no scoreboard change.
- Scoreboard:
  - set_en with set_wn=9, rs=9 -> busy_rs=1 next cycle.
  - Grant a write to $9 -> busy_rs=0 after the commit edge.
  - set and commit of $9 in the same cycle -> busy_rs stays 1.
- Reset mid-operation: grant a write to $5 and assert rst on the next edge -> we=0, scoreboard cleared, next grant with req_valid=111 is 001.
- WB_BYPASS_EN: commit wn=12, d=0xCAFEF00D with rs=12 and bit[12] set -> fwd_a_hit=1, fwd_a_data=0xCAFEF00D, busy_rs=0; rs=0 with wn=0 -> fwd_a_hit=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and named indices for the write-back path.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    typedef enum logic [4:0] {
        R_ZERO = 5'd0,
        R_SP   = 5'd29,
        R_RA   = 5'd31
    } reg_name_e;

    // Next round-robin position after index idx among n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin grant generator; the search starts at the
// pointer and the pointer moves past each winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = PTR_W'((int'(ptr_q) + k) % N);
                if (!found && req_i[idx]) begin
                    found        = 1'b1;
                    grant_o[idx] = 1'b1;
                    ptr_d        = PTR_W'(regfile_pkg::wrap_inc(int'(idx), N));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with a pending-write scoreboard for RAW
// detection. Optional commit-stage forwarding outputs under WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_wn,
    input  logic [NREQ*DATA_W-1:0] req_d,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we,
    output logic [ADDR_W-1:0]      wn,
    output logic [DATA_W-1:0]      d,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_wn,
    input  logic [ADDR_W-1:0]      rs,
    input  logic [ADDR_W-1:0]      rt,
    output logic                   busy_rs,
    output logic                   busy_rt
`ifdef WB_BYPASS_EN
    ,
    output logic                   fwd_a_hit,
    output logic [DATA_W-1:0]      fwd_a_data,
    output logic                   fwd_b_hit,
    output logic [DATA_W-1:0]      fwd_b_data
`endif
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NREQ-1:0]   grant;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_wn;
    logic [DATA_W-1:0] sel_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wn_q, wn_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [NREGS-1:0]  sb_q, sb_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_comb begin
        sel_wn = '0;
        sel_d  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_wn = req_wn[i*ADDR_W +: ADDR_W];
                sel_d  = req_d[i*DATA_W +: DATA_W];
            end
        end
    end

    // A granted write to $zero is consumed but never reaches the register file.
    always_comb begin
        we_d = 1'b0;
        wn_d = wn_q;
        d_d  = d_q;
        if (any_grant) begin
            we_d = (sel_wn != ZERO_IDX);
            wn_d = sel_wn;
            d_d  = sel_d;
        end
    end

    // Commit clears first so a same-cycle issue to the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (we_q) begin
            sb_d[wn_q] = 1'b0;
        end
        if (set_en && (set_wn != ZERO_IDX)) begin
            sb_d[set_wn] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            wn_q <= '0;
            d_q  <= '0;
            sb_q <= '0;
        end else begin
            we_q <= we_d;
            wn_q <= wn_d;
            d_q  <= d_d;
            sb_q <= sb_d;
        end
    end

    assign we = we_q;
    assign wn = wn_q;
    assign d  = d_q;

`ifdef WB_BYPASS_EN
    assign fwd_a_hit  = we_q && (wn_q == rs) && (rs != ZERO_IDX);
    assign fwd_b_hit  = we_q && (wn_q == rt) && (rt != ZERO_IDX);
    assign fwd_a_data = d_q;
    assign fwd_b_data = d_q;
    assign busy_rs    = sb_q[rs] & ~fwd_a_hit;
    assign busy_rt    = sb_q[rt] & ~fwd_b_hit;
`else
    assign busy_rs    = sb_q[rs];
    assign busy_rt    = sb_q[rt];
`endif

endmodule
